iq_frame_rx: RTL and testbench

- Parametrised I/Q deframer for the AT86RF215 LVDS baseband receive stream. Successor to the fixed 32-bit sync checker.
- Accepts one DDR bit pair per clock and searches both bit alignments for the frame header.
- Runs a SEARCH/VERIFY/LOCKED state machine with configurable acquire and loss thresholds.
- Emits sign-correct I/Q sample pairs with a one-cycle valid strobe. Sits between DDR_RECEIVE and the data FIFO.

---
 rtl/iq_frame_rx.sv | 152 +++++++++++++++
 tb/tb_iq_frame_rx.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/iq_frame_rx.sv
// I/Q deframer for the AT86RF215 LVDS rx stream; IQ_FRAME_RX_CHECK_EN adds I/Q trailer-bit checks.
// Latency: o_valid/o_i/o_q register one clock after a complete frame occupies the window.
// No backpressure: samples are strobed once per frame and must be taken on o_valid.
module iq_frame_rx #(
  parameter int SAMPLE_W   = 13,
  parameter int LOCK_COUNT = 3,
  parameter int LOSS_COUNT = 4,
  parameter int ERR_W      = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                i_enable,
  input  logic [1:0]          i_rx_d,
  input  logic                i_clear,
  output logic                o_valid,
  output logic [SAMPLE_W-1:0] o_i,
  output logic [SAMPLE_W-1:0] o_q,
  output logic                o_locked,
  output logic                o_idle,
  output logic [ERR_W-1:0]    o_err_count
);

  localparam int FRAME_BITS = 2 * (SAMPLE_W + 3);
  localparam int HALF       = FRAME_BITS / 2;
  localparam int PH_W       = $clog2(HALF);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(HALF - 1);
  localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);
  localparam logic [3:0] LOSS_N = 4'(LOSS_COUNT);

  typedef enum logic [1:0] {SEARCH = 2'd0, VERIFY = 2'd1, LOCKED = 2'd2} state_t;

  state_t                state;
  logic [FRAME_BITS:0]   sr;
  logic [PH_W-1:0]       ph;
  logic                  off;
  logic [3:0]            good;
  logic [3:0]            miss;
  logic [FRAME_BITS-1:0] frame0, frame1, frame_sel;
  logic                  match0, match1, match_sel, zero0, zero_sel, boundary;
  logic [3:0]            good_inc, miss_inc;

  function automatic logic hdr_ok(input logic [FRAME_BITS-1:0] f);
    logic ok;
    ok = (f[FRAME_BITS-1 -: 2] == 2'b10) && (f[HALF-1 -: 2] == 2'b01);
`ifdef IQ_FRAME_RX_CHECK_EN
    ok = ok && f[HALF] && !f[0];
`endif
    return ok;
  endfunction

  // Offset 1 excludes the newest bit, so it sees the window one bit earlier in the stream.
  assign frame0    = sr[FRAME_BITS-1:0];
  assign frame1    = sr[FRAME_BITS:1];
  assign frame_sel = off ? frame1 : frame0;
  assign match0    = hdr_ok(frame0);
  assign match1    = hdr_ok(frame1);
  assign match_sel = hdr_ok(frame_sel);
  assign zero0     = ~|frame0;
  assign zero_sel  = ~|frame_sel;
  assign boundary  = (ph == PH_LAST);
  assign good_inc  = good + 4'd1;
  assign miss_inc  = miss + 4'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= SEARCH;
      sr          <= '0;
      ph          <= '0;
      off         <= 1'b0;
      good        <= '0;
      miss        <= '0;
      o_valid     <= 1'b0;
      o_i         <= '0;
      o_q         <= '0;
      o_locked    <= 1'b0;
      o_idle      <= 1'b0;
      o_err_count <= '0;
    end else begin
      sr      <= {sr[FRAME_BITS-2:0], i_rx_d[1], i_rx_d[0]};
      ph      <= boundary ? '0 : ph + 1'b1;
      o_valid <= 1'b0;
      if (i_clear) o_err_count <= '0;

      if (!i_enable) begin
        state    <= SEARCH;
        o_locked <= 1'b0;
        good     <= '0;
        miss     <= '0;
      end else begin
        case (state)
          SEARCH: begin
            if (zero0) o_idle <= 1'b1;
            if (match0 || match1) begin
              off  <= !match0;
              ph   <= '0;
              good <= 4'd1;
              if (LOCK_COUNT == 1) begin
                state    <= LOCKED;
                o_locked <= 1'b1;
                miss     <= '0;
              end else begin
                state <= VERIFY;
              end
            end
          end
          VERIFY: begin
            if (boundary) begin
              if (match_sel) begin
                good <= good_inc;
                if (good_inc == LOCK_N) begin
                  state    <= LOCKED;
                  o_locked <= 1'b1;
                  miss     <= '0;
                end
              end else begin
                state <= SEARCH;
              end
            end
          end
          LOCKED: begin
            if (boundary) begin
              if (match_sel) begin
                o_valid <= 1'b1;
                o_i     <= frame_sel[FRAME_BITS-3 -: SAMPLE_W];
                o_q     <= frame_sel[HALF-3 -: SAMPLE_W];
                miss    <= '0;
                o_idle  <= 1'b0;
              end else if (zero_sel) begin
                // An idle link is not an error: drop lock without touching the counter.
                o_idle   <= 1'b1;
                state    <= SEARCH;
                o_locked <= 1'b0;
              end else begin
                miss <= miss_inc;
                if (!i_clear && !(&o_err_count)) o_err_count <= o_err_count + 1'b1;
                if (miss_inc == LOSS_N) begin
                  state    <= SEARCH;
                  o_locked <= 1'b0;
                end
              end
            end
          end
          default: begin
            state    <= SEARCH;
            o_locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_iq_frame_rx.sv
// Directed bench for iq_frame_rx: lock at both bit offsets, loss, idle, enable and clear handling.
module tb_iq_frame_rx;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_enable;
  logic [1:0]  i_rx_d;
  logic        i_clear;
  logic        o_valid;
  logic [12:0] o_i;
  logic [12:0] o_q;
  logic        o_locked;
  logic        o_idle;
  logic [15:0] o_err_count;

  int checks   = 0;
  int failures = 0;

  logic        carry;
  int          dly;
  logic        fv, fl, fid, last_lk;
  logic [15:0] ferr;
  int          rest_v;
  int          tot_v;

  logic [31:0] f_good, f_bad, f_zero, f_trl;

  always #5 clk = ~clk;

  iq_frame_rx dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_enable    (i_enable),
    .i_rx_d      (i_rx_d),
    .i_clear     (i_clear),
    .o_valid     (o_valid),
    .o_i         (o_i),
    .o_q         (o_q),
    .o_locked    (o_locked),
    .o_idle      (o_idle),
    .o_err_count (o_err_count)
  );

  function automatic logic [31:0] mk(input logic [12:0] i, input logic [12:0] q, input logic itrl);
    return {2'b10, i, itrl, 2'b01, q, 1'b0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [1:0] d);
    i_rx_d = d;
    @(posedge clk);
    #1;
  endtask

  // Sends one frame; with dly=1 the stream is one bit late (carry holds the spilled bit).
  // fv/fl/fid/ferr sample the cycle right after the previous frame's boundary.
  task automatic send(input logic [31:0] f, input bit clr0);
    logic [32:0] s;
    logic [1:0]  d;
    s      = {carry, f};
    rest_v = 0;
    for (int k = 0; k < 16; k++) begin
      if (dly != 0) d = {s[32-2*k], s[31-2*k]};
      else          d = {f[31-2*k], f[30-2*k]};
      i_clear = clr0 && (k == 0);
      step(d);
      i_clear = 1'b0;
      if (k == dly) begin
        fv   = o_valid;
        fl   = o_locked;
        fid  = o_idle;
        ferr = o_err_count;
      end else begin
        rest_v += int'(o_valid);
      end
    end
    last_lk = o_locked;
    carry   = f[0];
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    i_enable = 1'b1;
    i_clear  = 1'b0;
    i_rx_d   = 2'b00;
    carry    = 1'b0;
    #1;
    chk("rst_valid",  32'(o_valid),     32'd0);
    chk("rst_i",      32'(o_i),         32'd0);
    chk("rst_q",      32'(o_q),         32'd0);
    chk("rst_locked", 32'(o_locked),    32'd0);
    chk("rst_idle",   32'(o_idle),      32'd0);
    chk("rst_err",    32'(o_err_count), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    f_good = mk(13'h1001, 13'h0005, 1'b1);
    f_bad  = f_good & ~32'h8000_0000;
    f_zero = 32'h0;
    f_trl  = mk(13'h0001, 13'h0003, 1'b0);

    // Acquisition at offset 0
    do_reset();
    dly = 0;
    repeat (3) step(2'b00);
    for (int n = 1; n <= 20; n++) begin
      send(f_good, 1'b0);
      if (n >= 2) chk("lock_vld", 32'(fv), 32'(n >= 5));
      chk("lock_lk", 32'(last_lk), 32'(n >= 4));
      chk("lock_rest", 32'(rest_v), 32'd0);
    end
    chk("lock_i",    32'(o_i),    32'h1001);
    chk("lock_q",    32'(o_q),    32'h0005);
    chk("lock_idle", 32'(o_idle), 32'd0);

    // Three bad headers: lock held, errors counted, samples held
    send(f_bad, 1'b0);
    chk("c3_vld1", 32'(fv), 32'd1);
    chk("c3_lk1", 32'(last_lk), 32'd1);
    send(f_bad, 1'b0);
    chk("c3_vld2", 32'(fv), 32'd0);
    send(f_bad, 1'b0);
    chk("c3_vld3", 32'(fv), 32'd0);
    chk("c3_lk3", 32'(last_lk), 32'd1);
    send(f_good, 1'b0);
    chk("c3_vld4", 32'(fv), 32'd0);
    chk("c3_err", 32'(ferr), 32'd3);
    chk("c3_lk4", 32'(last_lk), 32'd1);
    chk("c3_hold_i", 32'(o_i), 32'h1001);
    send(f_good, 1'b0);
    chk("c3_resume", 32'(fv), 32'd1);

    // Four bad headers: lock drops at the fourth boundary
    for (int n = 1; n <= 4; n++) begin
      send(f_bad, 1'b0);
      chk("c4_lk", 32'(last_lk), 32'd1);
      chk("c4_vld", 32'(fv), 32'(n == 1));
    end
    send(f_zero, 1'b0);
    chk("c4_drop", 32'(fl), 32'd0);
    chk("c4_err", 32'(ferr), 32'd7);
    for (int n = 1; n <= 3; n++) send(f_good, 1'b0);
    chk("relock_pre", 32'(last_lk), 32'd0);
    send(f_good, 1'b0);
    chk("relock", 32'(fl), 32'd1);
    send(f_good, 1'b0);
    chk("relock_vld", 32'(fv), 32'd1);
    chk("relock_idle", 32'(o_idle), 32'd0);

    // Idle frame while locked
    send(f_zero, 1'b0);
    chk("idle_pre_vld", 32'(fv), 32'd1);
    chk("idle_pre_lk", 32'(last_lk), 32'd1);
    send(f_good, 1'b0);
    chk("idle_flag", 32'(fid), 32'd1);
    chk("idle_lk", 32'(fl), 32'd0);
    chk("idle_err", 32'(ferr), 32'd7);
    chk("idle_vld", 32'(fv), 32'd0);
    send(f_good, 1'b0);
    send(f_good, 1'b0);
    chk("idle_relock_pre", 32'(last_lk), 32'd0);
    send(f_good, 1'b0);
    chk("idle_relock", 32'(fl), 32'd1);
    send(f_good, 1'b0);
    chk("idle_relock_vld", 32'(fv), 32'd1);

    // Clear coinciding with a header miss
    send(f_bad, 1'b0);
    chk("clr_pre_vld", 32'(fv), 32'd1);
    send(f_good, 1'b1);
    chk("clr_err", 32'(ferr), 32'd0);
    chk("clr_lk", 32'(fl), 32'd1);
    chk("clr_vld", 32'(fv), 32'd0);
    send(f_bad, 1'b0);
    send(f_good, 1'b0);
    chk("clr_err_again", 32'(ferr), 32'd1);
    send(f_good, 1'b0);
    chk("clr_resume", 32'(fv), 32'd1);

    // Enable low for 5 cycles spanning a frame boundary
    for (int k = 0; k < 32; k++) begin
      i_enable = !(k >= 14 && k <= 18);
      step({f_good[31-2*(k%16)], f_good[30-2*(k%16)]});
      if (k == 0) chk("en_pre_vld", 32'(o_valid), 32'd1);
      if (k >= 14 && k <= 18) begin
        chk("en_vld", 32'(o_valid), 32'd0);
        chk("en_lk", 32'(o_locked), 32'd0);
      end
    end
    i_enable = 1'b1;
    chk("en_err_hold", 32'(o_err_count), 32'd1);

    // Mid-stream reset, then acquisition one bit late
    do_reset();
    dly = 1;
    for (int n = 1; n <= 8; n++) begin
      send(f_good, 1'b0);
      if (n >= 2) chk("off1_vld", 32'(fv), 32'(n >= 5));
      chk("off1_lk", 32'(last_lk), 32'(n >= 4));
      chk("off1_rest", 32'(rest_v), 32'd0);
    end
    chk("off1_i", 32'(o_i), 32'h1001);
    chk("off1_q", 32'(o_q), 32'h0005);

    // Frames whose I trailer bit is 0
    do_reset();
    dly   = 0;
    tot_v = 0;
    for (int n = 1; n <= 8; n++) begin
      send(f_trl, 1'b0);
      tot_v += int'(fv) + rest_v;
    end
`ifdef IQ_FRAME_RX_CHECK_EN
    chk("trl_lk", 32'(last_lk), 32'd0);
    chk("trl_vld_cnt", 32'(tot_v), 32'd0);
`else
    chk("trl_lk", 32'(last_lk), 32'd1);
    chk("trl_vld_cnt", 32'(tot_v), 32'd4);
    chk("trl_i", 32'(o_i), 32'h0001);
    chk("trl_q", 32'(o_q), 32'h0003);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
